// File: rtl/lsu_pkg.sv
// Shared encodings and big-endian lane helpers for the load/store data port.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Byte offset 0 is the most significant byte of the word.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = sgn ? 32'(b) : {24'd0, b};
      SZ_HALF: r = sgn ? 32'(h) : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[31:24] = wdata[7:0];
          2'd1:    r[23:16] = wdata[7:0];
          2'd2:    r[15:8]  = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[15:0]  = wdata[15:0];
        else        r[31:16] = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extract (loads) and lane merge (sub-word stores).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  assign rdata_o  = lane_extract(word_i, off_i, size_i, signed_i);
  assign merged_o = lane_merge(word_i, wdata_i, off_i, size_i);

endmodule

// File: rtl/lsu_data_port.sv
// Load/store unit driving the big-endian word data port of the unified memory.
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module lsu_data_port
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        mem_Clk,
  input  logic        mem_Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  output logic [31:0] data_memory_out_v,
  input  logic [31:0] data_memory_in_v
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores,
  output logic [15:0] perf_faults
`endif
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        write_q, signed_q, fault_q;
  logic [31:0] rdata_q, mem_a_q, out_q;
  logic [31:0] aligned_c, lane_rdata, lane_merged;
  logic        accept, fault_c;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign aligned_c = {req_addr[31:2], 2'b00};

  // Range check in 33 bits so addresses near 2^32 cannot wrap past the limit.
  always_comb begin
    fault_c = 1'b0;
    if (req_size == 2'd3)                          fault_c = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])        fault_c = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) fault_c = 1'b1;
    if (({1'b0, aligned_c} + 33'd3) >= 33'(MEM_BYTES)) fault_c = 1'b1;
  end

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fault_c)                             state_d = ST_RESP;
          else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
          else                                     state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = write_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_Clk) begin
    if (accept) begin
      addr_q   <= req_addr;
      size_q   <= req_size;
      write_q  <= req_write;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
      fault_q  <= fault_c;
    end
  end

  lsu_lane_align u_align (
    .word_i   (data_memory_in_v),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_o  (lane_rdata),
    .merged_o (lane_merged)
  );

  // Faulting requests leave the memory address and store word untouched.
  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      rdata_q <= 32'd0;
      mem_a_q <= 32'd0;
      out_q   <= 32'd0;
    end else begin
      if (accept) begin
        rdata_q <= 32'd0;
        if (!fault_c) mem_a_q <= aligned_c;
        if (!fault_c && req_write && req_size == SZ_WORD) out_q <= req_wdata;
      end
      if (state_q == ST_CAP) begin
        if (write_q) out_q   <= lane_merged;
        else         rdata_q <= lane_rdata;
      end
    end
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_fault        = (state_q == ST_RESP) && fault_q;
  assign resp_rdata        = rdata_q;
  assign data_memory_a     = mem_a_q;
  assign data_memory_read  = (state_q == ST_RD) || (state_q == ST_CAP);
  assign data_memory_write = (state_q == ST_WR);
  assign data_memory_out_v = out_q;

`ifdef LSU_PERF_CNT_EN
  logic [15:0] perf_loads_q, perf_stores_q, perf_faults_q;

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      perf_loads_q  <= 16'd0;
      perf_stores_q <= 16'd0;
      perf_faults_q <= 16'd0;
    end else if (state_q == ST_RESP) begin
      if (fault_q) begin
        if (perf_faults_q != 16'hFFFF) perf_faults_q <= perf_faults_q + 16'd1;
      end else if (write_q) begin
        if (perf_stores_q != 16'hFFFF) perf_stores_q <= perf_stores_q + 16'd1;
      end else begin
        if (perf_loads_q != 16'hFFFF) perf_loads_q <= perf_loads_q + 16'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_faults = perf_faults_q;
`endif

endmodule

// File: tb/tb_lsu_data_port.sv
// Randomized self-checking bench for lsu_data_port against a byte-level memory model.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_out, mem_in;
  logic        mem_rd, mem_wr;
`ifdef LSU_PERF_CNT_EN
  logic [15:0] perf_loads, perf_stores, perf_faults;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  lsu_data_port #(.MEM_BYTES(65536)) dut (
    .mem_Clk           (clk),
    .mem_Rst_n         (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_fault        (resp_fault),
    .data_memory_a     (mem_a),
    .data_memory_read  (mem_rd),
    .data_memory_write (mem_wr),
    .data_memory_out_v (mem_out),
    .data_memory_in_v  (mem_in)
`ifdef LSU_PERF_CNT_EN
    ,
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_faults       (perf_faults)
`endif
  );

  // Backing memory: written only here, by the DUT or by the preload port.
  logic [7:0]  mem  [0:65535];
  logic [7:0]  refm [0:65535];
  logic        init_en = 1'b0, pre_we = 1'b0;
  logic [15:0] pre_a = 16'd0;
  logic [31:0] pre_d = 32'd0;
  logic [15:0] ia;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 8));
  endfunction

  assign ia     = {mem_a[15:2], 2'b00};
  assign mem_in = {mem[ia], mem[ia + 16'd1], mem[ia + 16'd2], mem[ia + 16'd3]};

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
    end else if (pre_we) begin
      {mem[pre_a], mem[pre_a + 16'd1], mem[pre_a + 16'd2], mem[pre_a + 16'd3]} <= pre_d;
    end else if (mem_wr) begin
      {mem[ia], mem[ia + 16'd1], mem[ia + 16'd2], mem[ia + 16'd3]} <= mem_out;
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    return {refm[b], refm[b + 16'd1], refm[b + 16'd2], refm[b + 16'd3]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    return {mem[b], mem[b + 16'd1], mem[b + 16'd2], mem[b + 16'd3]};
  endfunction

  function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
    longint al;
    al = longint'({a[31:2], 2'b00});
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
           (al + 3 >= 65536);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [15:0] b;
    logic [31:0] v;
    b = a[15:0];
    if (sz == 2'd0) begin
      v = {24'd0, refm[b]};
      if (sg && refm[b][7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = {16'd0, refm[b], refm[b + 16'd1]};
      if (sg && refm[b][7]) v = v | 32'hFFFF0000;
    end else begin
      v = ref_word(a);
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [15:0] b;
    b = a[15:0];
    if (sz == 2'd0) refm[b] = wd[7:0];
    else if (sz == 2'd1) begin
      refm[b] = wd[15:8]; refm[b + 16'd1] = wd[7:0];
    end else begin
      refm[b] = wd[31:24]; refm[b + 16'd1] = wd[23:16];
      refm[b + 16'd2] = wd[15:8]; refm[b + 16'd3] = wd[7:0];
    end
  endtask

  task automatic set_word(input logic [15:0] a, input logic [31:0] w);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = w;
    @(negedge clk);
    pre_we = 1'b0;
    refm[a] = w[31:24]; refm[a + 16'd1] = w[23:16];
    refm[a + 16'd2] = w[15:8]; refm[a + 16'd3] = w[7:0];
  endtask

  // Drives one request and records what the ports did until the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int nrd, output int nwr, output logic port_ok,
                        output logic [31:0] wword, output logic tmo, output logic after_ok);
    int k;
    rd = 32'd0; flt = 1'b0; lat = 0; nrd = 0; nwr = 0; port_ok = 1'b1;
    wword = 32'd0; tmo = 1'b1; after_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_rd) nrd++;
      if (mem_wr) begin
        nwr++;
        wword = mem_out;
      end
      if ((mem_rd || mem_wr) && mem_a !== {a[31:2], 2'b00}) port_ok = 1'b0;
      if (mem_rd && mem_wr) port_ok = 1'b0;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; flt = resp_fault; tmo = 1'b0;
        break;
      end
    end
    @(negedge clk);
    after_ok = !resp_valid && req_ready;
  endtask

  task automatic check_req(input string name, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, wword, exp_rd, exp_w;
    logic flt, pok, tmo, aok, efault;
    int lat, nrd, nwr, elat, erd, ewr;
    efault = ref_fault(sz, a);
    exp_rd = (efault || w) ? 32'd0 : ref_load(sz, sg, a);
    elat   = efault ? 1 : (!w ? 3 : (sz == 2'd2 ? 2 : 4));
    erd    = (efault || (w && sz == 2'd2)) ? 0 : 2;
    ewr    = (!efault && w) ? 1 : 0;
    if (!efault && w) ref_store(sz, a, wd);
    exp_w  = ref_word(a);
    do_req(w, sz, sg, a, wd, rd, flt, lat, nrd, nwr, pok, wword, tmo, aok);
    ntests++;
    if (tmo) begin
      nfail++;
      $display("FAIL %s timeout: no resp_valid within 10 cycles addr=%h", name, a);
    end else if (lat != elat || flt !== efault || rd !== exp_rd || nrd != erd || nwr != ewr ||
                 !pok || !aok || (ewr == 1 && wword !== exp_w)) begin
      nfail++;
      $display("FAIL %s addr=%h w=%0d sz=%0d: lat=%0d/%0d fault=%0b/%0b rdata=%h/%h rd=%0d/%0d wr=%0d/%0d port_ok=%0b after_ok=%0b wword=%h/%h (got/expected)",
               name, a, w, sz, lat, elat, flt, efault, rd, exp_rd, nrd, erd, nwr, ewr,
               pok, aok, wword, exp_w);
    end
    if (!efault && w) begin
      ntests++;
      if (mem_word(a) !== exp_w) begin
        nfail++;
        $display("FAIL %s memword addr=%h got %h expected %h", name, a, mem_word(a), exp_w);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_en = 1'b1;
    repeat (2) @(negedge clk);
    init_en = 1'b0;
    for (int i = 0; i < 65536; i++) refm[i] = init_byte(i);
    @(negedge clk);
    ntests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'd0 ||
        mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_out !== 32'd0) begin
      nfail++;
      $display("FAIL reset_state ready=%b vld=%b flt=%b rdata=%h rd=%b wr=%b a=%h out=%h (expected 1,0,0,0,0,0,0,0)",
               req_ready, resp_valid, resp_fault, resp_rdata, mem_rd, mem_wr, mem_a, mem_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    set_word(16'h0100, 32'h8899AABB);
    check_req("load_sbyte_101", 1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
    check_req("load_ubyte_101", 1'b0, 2'd0, 1'b0, 32'h101, 32'd0);
    check_req("load_shalf_100", 1'b0, 2'd1, 1'b1, 32'h100, 32'd0);
    check_req("load_uhalf_102", 1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
    check_req("load_word_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
  endtask

  task automatic test_store();
    check_req("store_word_200", 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
    check_req("reload_word_200", 1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    set_word(16'h0300, 32'h11223344);
    check_req("store_half_302", 1'b1, 2'd1, 1'b0, 32'h302, 32'h5555ABCD);
    check_req("store_byte_301", 1'b1, 2'd0, 1'b0, 32'h301, 32'h000000E7);
    check_req("reload_word_300", 1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
  endtask

  task automatic test_faults();
    check_req("fault_half_103", 1'b0, 2'd1, 1'b0, 32'h103, 32'd0);
    check_req("fault_word_102", 1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
    check_req("fault_size3", 1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
    check_req("fault_word_fffe", 1'b0, 2'd2, 1'b0, 32'hFFFE, 32'd0);
    check_req("fault_store_range", 1'b1, 2'd0, 1'b0, 32'h10001, 32'h12);
    check_req("edge_word_fffc", 1'b0, 2'd2, 1'b0, 32'hFFFC, 32'd0);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h400; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    ntests++;
    if (mem_wr !== 1'b1) begin
      nfail++;
      $display("FAIL rst_wr_pulse write=%b expected 1", mem_wr);
    end
    rst_n = 1'b0;
    ref_store(2'd2, 32'h400, 32'hCAFEF00D);
    @(negedge clk);
    ntests++;
    if (mem_wr !== 1'b0 || resp_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rst_wr_abort write=%b resp_valid=%b expected 0,0", mem_wr, resp_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ntests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        nfail++;
        $display("FAIL rst_wr_release cycle %0d resp_valid=%b ready=%b expected 0,1", i, resp_valid, req_ready);
      end
    end
    check_req("rst_wr_kept", 1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0)      a = $urandom();
      else if (sel < 3)  a = 32'hFFF0 + $urandom_range(0, 31);
      else if (sel < 8)  a = 32'h100 + $urandom_range(0, 63);
      else               a = $urandom_range(0, 65535);
      check_req("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom());
    end
  endtask

`ifdef LSU_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_req("perf_ld0", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    check_req("perf_ld1", 1'b0, 2'd0, 1'b1, 32'h105, 32'd0);
    check_req("perf_st0", 1'b1, 2'd1, 1'b0, 32'h208, 32'h1234);
    check_req("perf_flt", 1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
    ntests++;
    if (perf_loads !== 16'd2 || perf_stores !== 16'd1 || perf_faults !== 16'd1) begin
      nfail++;
      $display("FAIL perf_counts got %0d/%0d/%0d expected 2/1/1", perf_loads, perf_stores, perf_faults);
    end
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rst_n = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_faults();
    test_reset_mid_write();
    test_random();
`ifdef LSU_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
